// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Operand/result bundle for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : LSB-first bit-serial subtractor, diff = a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave bus
);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    // Single full-subtractor cell operating on the current LSBs.
    assign w_d        = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_next  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new start just like IDLE, giving back-to-back operation.
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_br    <= bus.bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_res <= w_res_next;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_diff  <= w_res_next;
                        r_bout  <= w_br_next;
                        r_zero  <= (w_res_next == '0);
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.zero = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed-vector bench for serial_subtractor at WIDTH 4 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_subtractor_if #(.WIDTH(8)) bus8 ();

    serial_subtractor #(.WIDTH(4), .CW(3)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    serial_subtractor #(.WIDTH(8), .CW(4)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bo;
        logic       z;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One WIDTH=4 operation; a start pulse mid-flight must be ignored, operands get scrambled after acceptance.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [3:0] ed, input logic eb, input logic ez, input string nm);
        int cyc;
        int busy_ok;
        bus4.a = a; bus4.b = b; bus4.bin = bin; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0; bus4.a = ~a; bus4.b = ~b; bus4.bin = ~bin;
        cyc = 1;
        busy_ok = 1;
        while (!bus4.done && cyc < 20) begin
            if (!bus4.busy) busy_ok = 0;
            bus4.start = (cyc == 2);
            @(posedge clk); #1;
            cyc++;
        end
        bus4.start = 1'b0;
        check({nm, " latency"}, cyc, 5);
        check({nm, " busy"}, busy_ok, 1);
        check({nm, " busy_with_done"}, int'(bus4.busy), 0);
        check({nm, " diff"}, int'(bus4.diff), int'(ed));
        check({nm, " bout"}, int'(bus4.bout), int'(eb));
        check({nm, " zero"}, int'(bus4.zero), int'(ez));
        @(posedge clk); #1;
        check({nm, " done_pulse"}, int'({bus4.done, bus4.busy}), 0);
        check({nm, " hold"}, int'({bus4.diff, bus4.bout, bus4.zero}), int'({ed, eb, ez}));
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int cyc;
        int ed;
        int eb;
        ed = (int'(a) - int'(b) - int'(bin)) & 255;
        eb = (int'(a) < int'(b) + int'(bin)) ? 1 : 0;
        bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        cyc = 1;
        while (!bus8.done && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w8 latency", cyc, 9);
        check("w8 result", int'({bus8.diff, bus8.bout, bus8.zero}),
              (ed << 2) | (eb << 1) | ((ed == 0) ? 1 : 0));
    endtask

    initial begin
        int idx;
        int last_done;
        int ndone;
        vec_t ops [3];

        vecs[0]  = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0};
        vecs[1]  = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b0};
        vecs[2]  = '{4'h5, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1};
        vecs[3]  = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[4]  = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[5]  = '{4'h7, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0};
        vecs[6]  = '{4'h8, 4'h8, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[7]  = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0};
        vecs[8]  = '{4'h0, 4'hF, 1'b0, 4'h1, 1'b1, 1'b0};
        vecs[9]  = '{4'hA, 4'h3, 1'b1, 4'h6, 1'b0, 1'b0};
        vecs[10] = '{4'h1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1};
        vecs[11] = '{4'h2, 4'h3, 1'b0, 4'hF, 1'b1, 1'b0};

        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        #12;
        check("reset outputs", int'({bus4.busy, bus4.done, bus4.diff, bus4.bout, bus4.zero}), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle after reset", int'({bus4.busy, bus4.done}), 0);

        for (int i = 0; i < 12; i++)
            run4(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].z, $sformatf("vec%0d", i));

        // Back-to-back: start held high, new operands presented on each DONE cycle.
        ops[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0};
        ops[1] = '{4'h4, 4'h4, 1'b0, 4'h0, 1'b0, 1'b1};
        ops[2] = '{4'h1, 4'h6, 1'b1, 4'hA, 1'b1, 1'b0};
        bus4.a = ops[0].a; bus4.b = ops[0].b; bus4.bin = ops[0].bin; bus4.start = 1'b1;
        idx = 0;
        last_done = 0;
        for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
            @(posedge clk); #1;
            if (bus4.done) begin
                check($sformatf("b2b%0d result", idx), int'({bus4.diff, bus4.bout, bus4.zero}),
                      int'({ops[idx].d, ops[idx].bo, ops[idx].z}));
                if (idx > 0) check($sformatf("b2b%0d gap", idx), cyc - last_done, 5);
                last_done = cyc;
                idx++;
                if (idx < 3) begin
                    bus4.a = ops[idx].a; bus4.b = ops[idx].b; bus4.bin = ops[idx].bin;
                end else begin
                    bus4.start = 1'b0;
                end
            end else begin
                bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.bin = 1'($urandom);
            end
        end
        bus4.start = 1'b0;
        check("b2b count", idx, 3);
        @(posedge clk); #1;

        // Reset two shift cycles into an operation.
        bus4.a = 4'hC; bus4.b = 4'h1; bus4.bin = 1'b0; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midop reset outputs", int'({bus4.busy, bus4.done, bus4.diff, bus4.bout, bus4.zero}), 0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus4.done || bus4.busy) ndone++;
        end
        check("no done after reset", ndone, 0);
        run4(4'h7, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0, "post reset");

        run8(8'h00, 8'h00, 1'b1);
        run8(8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 500; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor. Computes diff = a - b - bin over WIDTH bits using one full-subtractor cell and a registered borrow.
- It is the inverse-direction companion to the team's full-adder cell. Datapath blocks use it for low-area subtraction and magnitude compare.
- Operands load in parallel on a start/done handshake. Each shift cycle produces one result bit.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CW, 6, internal bit-counter width; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- start  input  1  request a subtraction; sampled on rising edge.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result a - b - bin, modulo 2**WIDTH.
- bout  output  1  final borrow-out (1 means a < b + bin, unsigned).
- zero  output  1  diff == 0; valid with done and held afterwards.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, diff=0, bout=0, zero=0.
  - Counter, shift registers and borrow flop are cleared.
  - Takes effect immediately, including mid-operation; a partial result is discarded and no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at the edge: latch a into sa, b into sb, bin into borrow flop; clear counter; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (busy=1), each edge:
  - d = sa[0] ^ sb[0] ^ br.
  - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - Shift sa and sb right by 1.
  - Shift d into the result shift register at the MSB.
  - Increment counter.
  - On the edge that processes bit WIDTH-1, go to DONE.
- Result update:
  - The shift register is internal; the diff port updates only on the transition into DONE.
  - On that transition: diff <= completed value, bout <= br_next, zero <= (completed value == 0).
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - If start=1 at this edge, it is accepted (back-to-back operation): reload and go to SHIFT.
  - Otherwise go to IDLE.
- Latency: start sampled at edge k -> busy high from k through k+WIDTH-1 -> done=1 in the cycle after edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- Hold rule: diff, bout and zero hold their last values through IDLE and through the next SHIFT, until the next DONE.
- Boundaries:
  - start while busy=1 is ignored; it is not queued and the in-flight operation is unaffected.
  - Changes on a, b or bin after acceptance have no effect.
  - a == b with bin=0: diff=0, bout=0, zero=1.
  - a=0, b=0, bin=1: diff=all ones, bout=1.
  - Wrap-around is pure modulo arithmetic; no saturation.
  - done and busy are never high in the same cycle.

Test Plan:
- WIDTH=4, a=9, b=3, bin=0, start for 1 cycle -> busy high 4 cycles, then done pulse with diff=6, bout=0, zero=0.
- WIDTH=4, a=3, b=9, bin=0 -> diff=0xA, bout=1, zero=0; a=5, b=5, bin=0 -> diff=0, bout=0, zero=1.
- WIDTH=4, a=0, b=0, bin=1 -> diff=0xF, bout=1. Then a=0xF, b=0xF, bin=1 -> diff=0xF, bout=1.
- Back-to-back: hold start=1 continuously with new operands at each DONE cycle -> done pulses exactly WIDTH+1 cycles apart, each result correct; start pulses during busy do not alter the result.
- Reset mid-operation: assert rst_n=0 after 2 SHIFT cycles -> outputs zero immediately, no done. After release, a new start with a=7, b=2 -> diff=5.
- Randomised: 500 operand triples at WIDTH=8, compared against a reference model of (a - b - bin) mod 256 and borrow (a < b + bin) -> zero mismatches.
